// File: rtl/mem_bus_responder_pkg.sv
// mem_bus_responder_pkg: shared request/response types and credit sizing for the memory bus responder.
package mem_bus_responder_pkg;
    localparam int MBR_DATA_SIZE  = 64;
    localparam int MBR_ADDR_WIDTH = 26;
    localparam int MBR_TAG_WIDTH  = 8;
    localparam int MBR_RSP_QUEUE  = 4;
    localparam int MBR_CREDIT_W   = $clog2(MBR_RSP_QUEUE + 1);

    typedef struct packed {
        logic [8*MBR_DATA_SIZE-1:0] data;
        logic [MBR_TAG_WIDTH-1:0]   tag;
    } rsp_entry_t;

    typedef struct packed {
        logic                       rw;
        logic [MBR_ADDR_WIDTH-1:0]  addr;
        logic [MBR_DATA_SIZE-1:0]   byteen;
        logic [8*MBR_DATA_SIZE-1:0] data;
        logic [MBR_TAG_WIDTH-1:0]   tag;
    } req_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/VX_fifo_queue.sv
// VX_fifo_queue: circular-buffer FIFO; head entry stays stable until popped.
module VX_fifo_queue #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty    = (r_count == '0);
    assign w_pop    = pop && !empty;
    assign w_push   = push && (r_count != CW'(DEPTH));
    assign data_out = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= data_in;
    end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: SRAM-backed memory bus slave with fixed read latency and credit-guarded response queue.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int DATA_SIZE     = MBR_DATA_SIZE,
    parameter int ADDR_WIDTH    = MBR_ADDR_WIDTH,
    parameter int MEM_WORDS     = 1024,
    parameter int TAG_WIDTH     = MBR_TAG_WIDTH,
    parameter int LATENCY       = 2,
    parameter int RSP_QUEUE     = MBR_RSP_QUEUE,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_rw,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_SIZE-1:0]     req_byteen,
    input  logic [8*DATA_SIZE-1:0]   req_data,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [8*DATA_SIZE-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]     rsp_tag,
    input  logic                     rsp_ready,
    output logic [PERF_CTR_BITS-1:0] perf_reads,
    output logic [PERF_CTR_BITS-1:0] perf_writes,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CW    = credit_width(RSP_QUEUE);

    logic [8*DATA_SIZE-1:0]   r_mem [MEM_WORDS];
    logic [CW-1:0]            r_credits;
    logic [PERF_CTR_BITS-1:0] r_perf_reads;
    logic [PERF_CTR_BITS-1:0] r_perf_writes;
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;
    req_t                     w_req;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_unused_addr;
    logic                     w_fire;
    logic                     w_rd_fire;
    logic                     w_wr_fire;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_q_empty;
    rsp_entry_t               w_push_data;
    rsp_entry_t               w_q_out;

    assign w_req         = '{rw: req_rw, addr: req_addr, byteen: req_byteen, data: req_data, tag: req_tag};
    assign w_idx         = w_req.addr[IDX_W-1:0];
    assign w_unused_addr = |w_req.addr[ADDR_WIDTH-1:IDX_W];
    assign req_ready     = (r_credits != '0);
    assign w_fire        = req_valid && req_ready;
    assign w_rd_fire     = w_fire && !w_req.rw;
    assign w_wr_fire     = w_fire && w_req.rw;
    assign rsp_valid     = !w_q_empty;
    assign w_pop         = rsp_valid && rsp_ready;
    assign rsp_data      = w_q_out.data;
    assign rsp_tag       = w_q_out.tag;
    assign perf_reads    = r_perf_reads;
    assign perf_writes   = r_perf_writes;
    assign perf_stalls   = r_perf_stalls;

    always_ff @(posedge clk) begin
        if (w_wr_fire)
            for (int i = 0; i < DATA_SIZE; i++)
                if (w_req.byteen[i])
                    r_mem[w_idx][8*i +: 8] <= w_req.data[8*i +: 8];
    end

    // The accepting edge is the SRAM read; LATENCY-1 register stages follow before the queue.
    if (LATENCY == 1) begin : g_direct
        assign w_push      = w_rd_fire;
        assign w_push_data = '{data: r_mem[w_idx], tag: w_req.tag};
    end else begin : g_pipe
        logic [LATENCY-2:0] r_vld;
        rsp_entry_t         r_ent [LATENCY-1];
        always_ff @(posedge clk) begin
            if (reset)
                r_vld <= '0;
            else begin
                r_vld[0] <= w_rd_fire;
                for (int s = 1; s < LATENCY - 1; s++)
                    r_vld[s] <= r_vld[s-1];
            end
        end
        always_ff @(posedge clk) begin
            r_ent[0] <= '{data: r_mem[w_idx], tag: w_req.tag};
            for (int s = 1; s < LATENCY - 1; s++)
                r_ent[s] <= r_ent[s-1];
        end
        assign w_push      = r_vld[LATENCY-2];
        assign w_push_data = r_ent[LATENCY-2];
    end

    VX_fifo_queue #(
        .DATAW ($bits(rsp_entry_t)),
        .DEPTH (RSP_QUEUE)
    ) u_rsp_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .data_in  (w_push_data),
        .data_out (w_q_out),
        .empty    (w_q_empty)
    );

    // Credits reserve a queue slot per in-flight read, so the queue cannot overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits     <= CW'(RSP_QUEUE);
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
            r_perf_stalls <= '0;
        end else begin
            r_credits     <= r_credits - CW'(w_rd_fire) + CW'(w_pop);
            r_perf_reads  <= r_perf_reads + PERF_CTR_BITS'(w_rd_fire);
            r_perf_writes <= r_perf_writes + PERF_CTR_BITS'(w_wr_fire);
            r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(req_valid && !req_ready);
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: randomized bench for mem_bus_responder against a queue-based reference model.
module tb_mem_bus_responder;
    localparam int LAT = 2;
    localparam int RQ  = 4;
    localparam int MW  = 1024;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_rw;
    logic [25:0]  req_addr;
    logic [63:0]  req_byteen;
    logic [511:0] req_data;
    logic [7:0]   req_tag;
    logic         req_ready;
    logic         rsp_valid;
    logic [511:0] rsp_data;
    logic [7:0]   rsp_tag;
    logic         rsp_ready;
    logic [43:0]  perf_reads;
    logic [43:0]  perf_writes;
    logic [43:0]  perf_stalls;

    mem_bus_responder #(
        .DATA_SIZE     (64),
        .ADDR_WIDTH    (26),
        .MEM_WORDS     (MW),
        .TAG_WIDTH     (8),
        .LATENCY       (LAT),
        .RSP_QUEUE     (RQ),
        .PERF_CTR_BITS (44)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_byteen  (req_byteen),
        .req_data    (req_data),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_tag     (rsp_tag),
        .rsp_ready   (rsp_ready),
        .perf_reads  (perf_reads),
        .perf_writes (perf_writes),
        .perf_stalls (perf_stalls)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of expected responses, each with the first cycle it may appear.
    typedef struct {
        logic [511:0] data;
        logic [7:0]   tag;
        longint       rdy;
    } exp_t;

    exp_t         q[$];
    logic [511:0] m_mem [MW];
    longint       cyc = 0;
    longint       m_reads = 0;
    longint       m_writes = 0;
    longint       m_stalls = 0;

    always @(posedge clk) begin
        bit ready_exp;
        int idx;
        if (reset) begin
            q.delete();
            m_reads = 0;
            m_writes = 0;
            m_stalls = 0;
        end else begin
            ready_exp = (q.size() < RQ);
            idx = int'(req_addr) % MW;
            if (q.size() > 0 && q[0].rdy <= cyc && rsp_ready)
                void'(q.pop_front());
            if (req_valid && ready_exp) begin
                if (req_rw) begin
                    m_writes++;
                    for (int b = 0; b < 64; b++)
                        if (req_byteen[b]) m_mem[idx][8*b +: 8] = req_data[8*b +: 8];
                end else begin
                    m_reads++;
                    q.push_back('{data: m_mem[idx], tag: req_tag, rdy: cyc + LAT});
                end
            end else if (req_valid) begin
                m_stalls++;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit v;
        if (!reset) begin
            v = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("req_ready", 512'(req_ready), 512'(q.size() < RQ));
            chk("rsp_valid", 512'(rsp_valid), 512'(v));
            if (v) begin
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_tag", 512'(rsp_tag), 512'(q[0].tag));
            end
            chk("perf_reads", 512'(perf_reads), 512'(m_reads[43:0]));
            chk("perf_writes", 512'(perf_writes), 512'(m_writes[43:0]));
            chk("perf_stalls", 512'(perf_stalls), 512'(m_stalls[43:0]));
        end
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit rw, input logic [25:0] a, input logic [63:0] be,
                         input logic [511:0] d, input logic [7:0] t);
        bit acc;
        int g = 0;
        req_valid = 1; req_rw = rw; req_addr = a; req_byteen = be; req_data = d; req_tag = t;
        do begin
            acc = req_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 100);
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: request not accepted within 100 cycles");
        end
        req_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] w, d;
        logic [43:0]  r0, s0;
        int acc;
        bit a;
        reset = 1; req_valid = 0; req_rw = 0; req_addr = 0; req_byteen = 0;
        req_data = 0; req_tag = 0; rsp_ready = 1;
        idle(3);
        reset = 0;
        chk("reset_ready", 512'(req_ready), 512'(1));
        chk("reset_valid", 512'(rsp_valid), 512'(0));
        chk("reset_reads", 512'(perf_reads), 512'(0));

        for (int i = 0; i < MW; i++) issue(1, 26'(i), '1, rnd512(), 0);

        issue(1, 26'd5, '1, {64{8'hA5}}, 0);
        issue(0, 26'd5, 0, 0, 8'h3);
        chk("a5_not_yet_valid", 512'(rsp_valid), 512'(0));
        idle(1);
        chk("a5_valid", 512'(rsp_valid), 512'(1));
        chk("a5_data", rsp_data, {64{8'hA5}});
        chk("a5_tag", 512'(rsp_tag), 512'(8'h3));

        w = {8{64'h1122334455667788}};
        issue(1, 26'd9, '1, w, 0);
        issue(1, 26'd9, 64'h1, {512{1'b1}}, 0);
        issue(0, 26'd9, 0, 0, 8'h4);
        idle(1);
        w[7:0] = 8'hFF;
        chk("partial_data", rsp_data, w);
        idle(2);

        rsp_ready = 0;
        s0 = perf_stalls;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1; req_rw = 0; req_addr = 26'(k + 100); req_tag = 8'(acc);
            a = req_ready;
            @(posedge clk);
            #1;
            if (a) acc++;
        end
        req_valid = 0;
        chk("stall_accepted", 512'(acc), 512'(4));
        chk("stall_ready_low", 512'(req_ready), 512'(0));
        chk("stall_count", 512'(perf_stalls - s0), 512'(2));
        chk("stall_head_valid", 512'(rsp_valid), 512'(1));
        chk("stall_head_tag", 512'(rsp_tag), 512'(0));
        rsp_ready = 1;
        idle(1);
        chk("ready_after_pop", 512'(req_ready), 512'(1));
        idle(5);

        r0 = perf_reads;
        s0 = perf_stalls;
        for (int k = 0; k < 100; k++) issue(0, 26'($urandom), 0, 0, 8'($urandom));
        chk("b2b_reads", 512'(perf_reads - r0), 512'(100));
        chk("b2b_stalls", 512'(perf_stalls - s0), 512'(0));
        idle(4);

        d = rnd512();
        issue(1, 26'd7, '1, d, 0);
        issue(0, 26'(MW + 7), 0, 0, 8'h77);
        idle(1);
        chk("alias_data", rsp_data, d);
        chk("alias_tag", 512'(rsp_tag), 512'(8'h77));
        idle(2);

        rsp_ready = 0;
        for (int k = 0; k < 3; k++) issue(0, 26'(k), 0, 0, 8'(8'hE0 + k));
        idle(3);
        chk("pre_reset_valid", 512'(rsp_valid), 512'(1));
        reset = 1;
        idle(1);
        reset = 0;
        chk("drop_valid", 512'(rsp_valid), 512'(0));
        chk("drop_ready", 512'(req_ready), 512'(1));
        chk("drop_reads", 512'(perf_reads), 512'(0));
        chk("drop_writes", 512'(perf_writes), 512'(0));
        chk("drop_stalls", 512'(perf_stalls), 512'(0));
        rsp_ready = 1;
        idle(6);

        for (int k = 0; k < 400; k++) begin
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req_valid  = ($urandom_range(0, 4) < 3);
            req_rw     = $urandom_range(0, 1);
            req_addr   = 26'($urandom_range(0, 15) + ($urandom_range(0, 1) ? 3 * MW : 0));
            req_byteen = {$urandom, $urandom};
            req_data   = rnd512();
            req_tag    = 8'($urandom);
            idle(1);
        end
        req_valid = 0;
        rsp_ready = 1;
        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
